register_file_scoreboard: RTL and testbench
===========================================

Name: register_file_scoreboard

Overview:
Parametrised successor to the core's integer register file. It provides a configurable number of combinational read ports, one registered write port, optional write-to-read bypass, and a per-register busy scoreboard for in-flight multi-cycle producers (load, mul/div). It supports RV32I (32 registers) and RV32E (16 registers) and sits between the decoder/issue logic and the writeback stage.

Parameters:
XLEN, 32, data width of each register.
RV32I, 1, 1 gives 32 registers (x0-x31); 0 gives 16 registers (x0-x15), and only address bits [3:0] are used.
NUM_READ_PORTS, 2, number of independent read ports (1..4).
WRITE_BYPASS, 1, 1 forwards same-cycle write data to matching read ports; 0 means reads return stored contents only.
DEBUG_REG, 31, index of the register driven on debug_output; forced to 15 when RV32I=0 and DEBUG_REG>15.

Ports:
clock  in  1  rising-edge clock; the only clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
read_addr  in  NUM_READ_PORTS*5  packed read addresses; port k uses bits [5k+4:5k]
read_data  out  NUM_READ_PORTS*XLEN  packed read data; port k uses bits [XLEN*k+XLEN-1:XLEN*k]
read_busy  out  NUM_READ_PORTS  1 = addressed register has an outstanding reservation
write_addr  in  5  destination register
write_data  in  XLEN  writeback value
write_enable  in  1  commit write_data at the next rising edge
reserve_addr  in  5  register to mark busy
reserve_enable  in  1  set busy bit at the next rising edge
debug_output  out  XLEN  current stored contents of DEBUG_REG

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0; all busy bits clear to 0.
  - debug_output is 0 and every read_data is 0 while reset is held.
  - read_busy is all 0.
  - Deassertion takes effect at the first rising edge with reset=1.
  - Reset asserted mid-operation discards any write or reservation in that cycle.
- Addressing:
  - RV32I=0: bit 4 of every address is ignored (x17 aliases x1).
  - x0 is not stored. Reads of x0 return 0 with read_busy=0. Writes and reservations to x0 are dropped.
- Write:
  - registered; on a rising edge with write_enable=1, the register at write_addr takes write_data.
  - new value is visible in stored reads the cycle after the edge.
- Read:
  - fully combinational, zero latency; each port is independent.
  - Duplicate addresses across ports return identical data.
  - WRITE_BYPASS=1 and write_enable=1 and read address == write_addr (nonzero): read_data = write_data in the same cycle.
  - WRITE_BYPASS=0: the old value is returned until the edge.
- Scoreboard:
  - busy[i] set at the edge when reserve_enable=1 and reserve_addr=i.
  - busy[i] cleared at the edge when write_enable=1 and write_addr=i.
  - Same-edge reserve and write to the same register: the register takes the write data and busy stays 1 (a new producer has issued).
  - Reserving an already-busy register leaves it busy (no count; one producer per register).
  - Write without a prior reservation is legal and leaves busy=0.
  - read_busy[k] = busy[addr_k], except when WRITE_BYPASS=1 and a same-cycle write hits addr_k; then read_busy[k]=0 because the data is forwarded.
- debug_output reflects stored contents only and is never bypassed.
- The read mux must be a single-level, fully decoded select per port (one case arm per register), not a two-level mux.

Test Plan:
1. Reset with reset=0, then release; read x5 on both ports -> read_data=0, read_busy=0, debug_output=0.
2. Write x5=0xDEADBEEF; next cycle read x5 on ports 0 and 1 -> both 0xDEADBEEF. Write x0=0x1234; read x0 -> 0.
3. WRITE_BYPASS=1: same cycle as write x7=0xA5A5A5A5, read x7 -> 0xA5A5A5A5 with read_busy=0. Repeat with WRITE_BYPASS=0 -> old value 0.
4. Reserve x9; next cycle read x9 -> read_busy=1. Write x9=0x42 -> read_busy=0 after the edge and data=0x42. Same-edge reserve+write x9=0x77 -> data 0x77, busy=1.
5. RV32I=0: write x17=0x11111111 -> x1 reads 0x11111111. Write x15=0xCAFEF00D -> debug_output=0xCAFEF00D the next cycle.
6. Reserve x3 and write x3=0x55 pending; assert reset for half a cycle before the edge -> x3=0, busy=0, and the write is lost.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Integer register file with NUM_READ_PORTS combinational read ports, one
//   registered write port, optional same-cycle write->read forwarding, and a
//   per-register busy scoreboard for in-flight multi-cycle producers.
//   RV32I=1 gives x0..x31; RV32I=0 gives x0..x15 and ignores address bit 4.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   read_addr      NUM_READ_PORTS x 5-bit packed read addresses
//   read_data      NUM_READ_PORTS x XLEN packed read data
//   read_busy      per-port busy flag of the addressed register
//   write_addr     writeback destination
//   write_data     writeback value
//   write_enable   commit write_data at the next rising edge
//   reserve_addr   register to mark busy
//   reserve_enable set the busy bit at the next rising edge
//   debug_output   stored contents of DEBUG_REG (never forwarded)

// One read port: fully decoded AND-OR select over every register, then an
// optional forwarding override.
module rf_read_port #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int WRITE_BYPASS = 1
) (
  input  logic                       en_i,      // low while reset is held
  input  logic [AW-1:0]              addr_i,
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [NREGS-1:0]           busy_i,
  input  logic                       wr_en_i,   // already excludes x0
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [XLEN-1:0]            wr_data_i,
  output logic [XLEN-1:0]            data_o,
  output logic                       busy_o
);
  logic [XLEN-1:0] stored;
  logic            fwd;

  always_comb begin
    stored = '0;
    // Entry 0 is held at zero by the write logic, so including it here keeps
    // x0 reading as 0 without a special case.
    for (int r = 0; r < NREGS; r++)
      stored = stored | ({XLEN{addr_i == AW'(r)}} & regs_i[r]);
    fwd    = (WRITE_BYPASS != 0) && en_i && wr_en_i && (wr_addr_i == addr_i);
    data_o = fwd ? wr_data_i : stored;
    // Forwarded data is final, so the reservation no longer matters.
    busy_o = fwd ? 1'b0 : busy_i[addr_i];
  end
endmodule

module register_file_scoreboard #(
  parameter int XLEN           = 32,
  parameter int RV32I          = 1,
  parameter int NUM_READ_PORTS = 2,
  parameter int WRITE_BYPASS   = 1,
  parameter int DEBUG_REG      = 31
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ_PORTS*5-1:0]    read_addr,
  output logic [NUM_READ_PORTS*XLEN-1:0] read_data,
  output logic [NUM_READ_PORTS-1:0]      read_busy,
  input  logic [4:0]                     write_addr,
  input  logic [XLEN-1:0]                write_data,
  input  logic                           write_enable,
  input  logic [4:0]                     reserve_addr,
  input  logic                           reserve_enable,
  output logic [XLEN-1:0]                debug_output
);
  localparam int NREGS   = (RV32I != 0) ? 32 : 16;
  localparam int AW      = (RV32I != 0) ? 5 : 4;
  localparam int DBG_IDX = ((RV32I == 0) && (DEBUG_REG > 15)) ? 15 : DEBUG_REG;
  localparam logic [AW-1:0] DBG_SEL = AW'(DBG_IDX);

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
  } rsv_req_t;

  wr_req_t  wr;
  rsv_req_t rsv;

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;

  // In RV32E mode address bit 4 is deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_addr, write_addr, reserve_addr};

  // Requests aimed at x0 are dropped here so nothing downstream sees them.
  always_comb begin
    wr.addr  = write_addr[AW-1:0];
    wr.data  = write_data;
    wr.en    = write_enable && (write_addr[AW-1:0] != '0);
    rsv.addr = reserve_addr[AW-1:0];
    rsv.en   = reserve_enable && (reserve_addr[AW-1:0] != '0);
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr.en) begin
      regs_d[wr.addr] = wr.data;
      busy_d[wr.addr] = 1'b0;
    end
    // A reservation landing on the same edge as the write belongs to a newer
    // producer, so it wins over the clear.
    if (rsv.en)
      busy_d[rsv.addr] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
    rf_read_port #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .WRITE_BYPASS(WRITE_BYPASS)
    ) u_port (
      .en_i      (reset),
      .addr_i    (read_addr[5*k +: AW]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .wr_en_i   (wr.en),
      .wr_addr_i (wr.addr),
      .wr_data_i (wr.data),
      .data_o    (read_data[XLEN*k +: XLEN]),
      .busy_o    (read_busy[k])
    );
  end

  assign debug_output = regs_q[DBG_SEL];
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Drives three configurations from one stimulus stream:
//   dut 0: RV32I, bypass on   dut 1: RV32I, bypass off   dut 2: RV32E, bypass on
module tb_register_file_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  read_addr;
  logic [4:0]  write_addr, reserve_addr;
  logic [31:0] write_data;
  logic        write_enable, reserve_enable;

  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rb_a, rb_b, rb_c;
  logic [31:0] dbg_a, dbg_b, dbg_c;

  always #5 clock = ~clock;

  register_file_scoreboard #(.XLEN(32), .RV32I(1), .NUM_READ_PORTS(2), .WRITE_BYPASS(1), .DEBUG_REG(31)) dut_a (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd_a), .read_busy(rb_a),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .reserve_addr(reserve_addr), .reserve_enable(reserve_enable), .debug_output(dbg_a));
  register_file_scoreboard #(.XLEN(32), .RV32I(1), .NUM_READ_PORTS(2), .WRITE_BYPASS(0), .DEBUG_REG(31)) dut_b (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd_b), .read_busy(rb_b),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .reserve_addr(reserve_addr), .reserve_enable(reserve_enable), .debug_output(dbg_b));
  register_file_scoreboard #(.XLEN(32), .RV32I(0), .NUM_READ_PORTS(2), .WRITE_BYPASS(1), .DEBUG_REG(31)) dut_c (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd_c), .read_busy(rb_c),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .reserve_addr(reserve_addr), .reserve_enable(reserve_enable), .debug_output(dbg_c));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays of register values and busy flags.
  logic [31:0] m_mem  [3][32];
  bit          m_busy [3][32];

  function automatic int idx(int c, logic [4:0] a);
    return (c == 2) ? int'(a[3:0]) : int'(a);
  endfunction

  function automatic bit has_bypass(int c);
    return c != 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 32; r++) begin
        m_mem[c][r]  = '0;
        m_busy[c][r] = 1'b0;
      end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        int wi = idx(c, write_addr);
        int ri = idx(c, reserve_addr);
        if (write_enable && wi != 0) begin
          m_mem[c][wi]  = write_data;
          m_busy[c][wi] = 1'b0;
        end
        if (reserve_enable && ri != 0) m_busy[c][ri] = 1'b1;
      end
    end
  endtask

  // Layout: {data1, data0, busy1, busy0, debug}
  function automatic logic [97:0] expect_out(int c);
    logic [31:0] d [2];
    logic        b [2];
    for (int k = 0; k < 2; k++) begin
      int i = idx(c, read_addr[5*k +: 5]);
      if (i == 0) begin
        d[k] = '0; b[k] = 1'b0;
      end else if (has_bypass(c) && reset && write_enable && idx(c, write_addr) == i) begin
        d[k] = write_data; b[k] = 1'b0;
      end else begin
        d[k] = m_mem[c][i]; b[k] = m_busy[c][i];
      end
    end
    return {d[1], d[0], b[1], b[0], m_mem[c][(c == 2) ? 15 : 31]};
  endfunction

  function automatic logic [97:0] actual(int c);
    case (c)
      0:       return {rd_a, rb_a, dbg_a};
      1:       return {rd_b, rb_b, dbg_b};
      default: return {rd_c, rb_c, dbg_c};
    endcase
  endfunction

  task automatic chk(string nm, logic [97:0] act, logic [97:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(string nm);
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s/dut%0d", nm, c), actual(c), expect_out(c));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit we, logic [4:0] wa, logic [31:0] wd, bit re, logic [4:0] rsa,
                       logic [4:0] r0, logic [4:0] r1);
    write_enable = we; write_addr = wa; write_data = wd;
    reserve_enable = re; reserve_addr = rsa;
    read_addr = {r1, r0};
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3) + 16 * $urandom_range(0, 1));
  endfunction

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          re;
    logic [4:0]  rsa;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;   // expected dut 0 read data, checked before the edge
    logic [1:0]  eb;       // expected dut 0 read_busy {port1, port0}
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0, 0,  32'h0,        0, 0, 5,  5,  32'h0,        32'h0,        2'b00};
    tbl[1]  = '{1, 5,  32'hDEADBEEF, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        2'b00};
    tbl[2]  = '{1, 0,  32'h00001234, 0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    tbl[3]  = '{0, 0,  32'h0,        0, 0, 0,  5,  32'h0,        32'hDEADBEEF, 2'b00};
    tbl[4]  = '{1, 7,  32'hA5A5A5A5, 0, 0, 7,  0,  32'hA5A5A5A5, 32'h0,        2'b00};
    tbl[5]  = '{0, 0,  32'h0,        1, 9, 9,  7,  32'h0,        32'hA5A5A5A5, 2'b00};
    tbl[6]  = '{0, 0,  32'h0,        0, 0, 9,  9,  32'h0,        32'h0,        2'b11};
    tbl[7]  = '{1, 9,  32'h00000042, 0, 0, 9,  5,  32'h00000042, 32'hDEADBEEF, 2'b00};
    tbl[8]  = '{0, 0,  32'h0,        0, 0, 9,  9,  32'h00000042, 32'h00000042, 2'b00};
    tbl[9]  = '{1, 9,  32'h00000077, 1, 9, 9,  9,  32'h00000077, 32'h00000077, 2'b00};
    tbl[10] = '{0, 0,  32'h0,        0, 0, 9,  9,  32'h00000077, 32'h00000077, 2'b11};
    tbl[11] = '{0, 0,  32'h0,        1, 9, 9,  0,  32'h00000077, 32'h0,        2'b01};
    tbl[12] = '{1, 17, 32'h11111111, 0, 0, 1,  17, 32'h0,        32'h11111111, 2'b00};
    tbl[13] = '{0, 0,  32'h0,        0, 0, 1,  17, 32'h0,        32'h11111111, 2'b00};
    tbl[14] = '{1, 15, 32'hCAFEF00D, 0, 0, 15, 0,  32'hCAFEF00D, 32'h0,        2'b00};
    tbl[15] = '{0, 0,  32'h0,        0, 0, 31, 15, 32'h0,        32'hCAFEF00D, 2'b00};

    // Reset held with a pending write: nothing may leak through the bypass.
    reset = 1'b0;
    model_reset();
    drive(1, 5, 32'hFFFF0000, 1, 5, 5, 5);
    #1;
    chk("reset_hold", actual(0), 98'h0);
    check_model("reset_hold");
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5, 5);
    #1;
    chk("reset_release", actual(0), 98'h0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].rsa, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d", i), {32'h0, rd_a, rb_a}, {32'h0, tbl[i].e1, tbl[i].e0, tbl[i].eb});
      check_model($sformatf("vec%0d", i));
      tick();
    end

    // RV32E aliasing and debug register (x17 landed in x1, x15 is the debug reg).
    drive(0, 0, 0, 0, 0, 1, 15);
    #1;
    chk("rv32e_alias", {34'h0, rd_c}, {34'h0, 32'hCAFEF00D, 32'h11111111});
    chk("rv32e_debug", {66'h0, dbg_c}, {66'h0, 32'hCAFEF00D});

    // Debug output is never forwarded.
    drive(1, 31, 32'h31313131, 0, 0, 31, 0);
    #1;
    chk("debug_no_bypass", {66'h0, dbg_a}, 98'h0);
    check_model("debug_no_bypass");
    tick();
    chk("debug_after_write", {66'h0, dbg_a}, {66'h0, 32'h31313131});

    // Bypass off returns the old value until the edge.
    drive(1, 7, 32'h5A5A5A5A, 0, 0, 7, 7);
    #1;
    chk("nobyp_old", {32'h0, rd_b, rb_b}, {32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00});
    chk("byp_new",   {32'h0, rd_a, rb_a}, {32'h0, 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00});
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    #1;
    chk("nobyp_after", {32'h0, rd_b, rb_b}, {32'h0, 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00});

    // Reserve+write pending, reset asserted across the edge: both are lost.
    drive(1, 3, 32'h00000055, 1, 3, 3, 3);
    #1;
    check_model("pre_midreset");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    chk("midreset_hold", actual(0), 98'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 3, 3);
    #1;
    chk("midreset_lost", {32'h0, rd_a, rb_a}, 98'h0);
    check_model("midreset_lost");

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 2) == 0),
            rnd_addr(), rnd_addr(), rnd_addr());
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        check_model($sformatf("rnd_rst%0d", n));
        @(posedge clock);
        #1;
        reset = 1'b1;
      end else begin
        #1;
        check_model($sformatf("rnd%0d", n));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
